// File: rtl/gcd_pack.sv
// Shared types and defaults for the subtractive-Euclid GCD block.
package gcd_pack;

    typedef enum logic {GCD_IDLE, GCD_CALC} gcd_state_t;

    localparam int GCD_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, comparators and subtractors for subtractive Euclid.
// Latency: one compare/subtract step per cycle while step is asserted.
// Backpressure: none; load and step are strobes owned by the sequencer.
module gcd_datapath
    import gcd_pack::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             x_zero,
    output logic             y_zero,
    output logic             eq,
    output logic             gt
);

    assign x_zero = (x == '0);
    assign y_zero = (y == '0);
    assign eq     = (x == y);
    assign gt     = (x > y);

    // Subtraction is only taken on the larger operand, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= a_in;
            y <= b_in;
        end else if (step) begin
            if (gt) x <= x - y;
            else    y <= y - x;
        end
    end

endmodule

// File: rtl/gcd_ctrl.sv
// GCD sequencer: captures operands on a start edge, steps the datapath, posts sticky done.
// Latency: done rises N+2 cycles after the start edge (N = subtract steps).
// Backpressure: none; start edges arriving while busy are dropped.
module gcd_ctrl
    import gcd_pack::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] iters
);

    gcd_state_t       state;
    logic             start_q;
    logic             start_edge;
    logic             load;
    logic             step;
    logic             finish;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             x_zero;
    logic             y_zero;
    logic             eq;
    logic             gt;

    assign start_edge = start & ~start_q;
    assign finish     = x_zero | y_zero | eq;
    assign load       = (state == GCD_IDLE) & start_edge;
    assign step       = (state == GCD_CALC) & ~finish;

    gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .a_in   (a_in),
        .b_in   (b_in),
        .x      (x),
        .y      (y),
        .x_zero (x_zero),
        .y_zero (y_zero),
        .eq     (eq),
        .gt     (gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= GCD_IDLE;
            start_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            iters   <= '0;
        end else begin
            start_q <= start;
            case (state)
                GCD_IDLE: begin
                    if (start_edge) begin
                        state <= GCD_CALC;
                        busy  <= 1'b1;
                        iters <= '0;
                        done  <= 1'b0;
                    end else if (ack) begin
                        done  <= 1'b0;
                    end
                end
                GCD_CALC: begin
                    // done is already clear here, so a coincident ack cannot beat the set.
                    if (finish) begin
                        state  <= GCD_IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= x_zero ? y : x;
                    end else if (iters != '1) begin
                        iters  <= iters + WIDTH'(1);
                    end
                end
                default: state <= GCD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl: stimulus pushes expected completions, a monitor pops on each done rise.
module tb_gcd_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ack;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] iters;

    gcd_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .ack    (ack),
        .busy   (busy),
        .done   (done),
        .result (result),
        .iters  (iters)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] it;
        int           cy;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic done_q = 1'b0;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every rising done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1 && done_q !== 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: done rose with result %0d, no completion expected", result);
            end else begin
                e = sbq.pop_front();
                check("result", longint'(result), longint'(e.res));
                check("iters", longint'(iters), longint'(e.it));
                check("done_cycle", longint'(cyc), longint'(e.cy));
            end
        end
        done_q = done;
    end

    // Launch one run; busy must be high in cycles 1..n+1 and low in n+2.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic [W-1:0] it,
                       input int n, input int ack_at);
        int c0;
        @(posedge clk); #1;
        start = 1'b1; a_in = a; b_in = b;
        c0 = cyc;
        sbq.push_back('{res, it, c0 + n + 2});
        for (int k = 1; k <= n + 2; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            ack = (k == ack_at);
            @(negedge clk);
            if (k <= 3 || k >= n)
                check("busy", longint'(busy), (k <= n + 1) ? 1 : 0);
        end
        ack = 1'b0;
    endtask

    initial begin
        int c0;
        rst = 1'b1; start = 1'b0; ack = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_result", longint'(result), 0);
        check("rst_iters", longint'(iters), 0);
        @(posedge clk); #1 rst = 1'b0;

        run(16'd12, 16'd8, 16'd4, 16'd2, 2, 0);
        // done stays set until ack is sampled, then clears the next cycle
        @(posedge clk); #1 ack = 1'b1;
        @(negedge clk); check("done_sticky", longint'(done), 1);
        @(posedge clk); #1 ack = 1'b0;
        @(negedge clk); check("done_ack_clear", longint'(done), 0);

        run(16'd0, 16'd9, 16'd9, 16'd0, 0, 0);
        run(16'd0, 16'd0, 16'd0, 16'd0, 0, 0);
        run(16'd21, 16'd6, 16'd3, 16'd4, 4, 0);

        // Start edge during CALC is dropped
        @(posedge clk); #1 start = 1'b1; a_in = 16'd12; b_in = 16'd8;
        c0 = cyc;
        sbq.push_back('{16'd4, 16'd2, c0 + 4});
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1; a_in = 16'd5; b_in = 16'd5;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); check("ignored_busy_c3", longint'(busy), 1);
        @(posedge clk); #1;
        @(negedge clk); check("ignored_busy_c4", longint'(busy), 0);

        // Relaunch from IDLE with done=1, ack coincident with completion
        run(16'd5, 16'd5, 16'd5, 16'd0, 0, 1);
        check("ack_coincide_c2", longint'(done), 1);
        @(posedge clk); #1;
        @(negedge clk); check("ack_coincide_c3", longint'(done), 1);

        // Reset mid-run, start held high across release
        @(posedge clk); #1 start = 1'b1; a_in = 16'd12; b_in = 16'd8;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1; start = 1'b1; a_in = 16'd0; b_in = 16'd9;
        @(posedge clk); #1 rst = 1'b0;
        c0 = cyc;
        sbq.push_back('{16'd9, 16'd0, c0 + 2});
        @(negedge clk);
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_result", longint'(result), 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); check("relaunch_busy", longint'(busy), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);

        run(16'd65535, 16'd1, 16'd1, 16'd65534, 65534, 0);

        repeat (5) @(negedge clk);
        check("sb_drained", longint'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
